// File: rtl/comb_lock_pkg.sv
// rtl/comb_lock_pkg.sv - shared code width and switch conditioner state encoding
package comb_lock_pkg;

    localparam int CODE_W = 3;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } cond_state_t;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-bit flop-chain synchronizer for asynchronous levels
module bit_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the asynchronous input through DEPTH flops; the first stage may go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchronizes and debounces the A/B/C slide-switch code
module switch_conditioner
    import comb_lock_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] switch_raw,
    output logic [CODE_W-1:0] switch_clean,
    output logic              code_strobe,
    output logic              stable
);

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CODE_W-1:0] s;
    cond_state_t       state;
    cond_state_t       state_nxt;
    logic [CODE_W-1:0] cand;
    logic [CODE_W-1:0] cand_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CODE_W-1:0] clean_nxt;
    logic              strobe_nxt;

    bit_sync #(
        .WIDTH (CODE_W),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (switch_raw),
        .q     (s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STABLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions: a candidate must be seen unchanged for
    // DEBOUNCE_CYCLES further samples before it replaces the clean code.
    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        cnt_nxt    = cnt;
        clean_nxt  = switch_clean;
        strobe_nxt = 1'b0;
        case (state)
            ST_STABLE: begin
                if (s != switch_clean) begin
                    cand_nxt  = s;
                    cnt_nxt   = '0;
                    state_nxt = ST_SETTLING;
                end
            end
            ST_SETTLING: begin
                if (s != cand) begin
                    // Bounce: restart the qualification window on the new value.
                    cand_nxt = s;
                    cnt_nxt  = '0;
                end else if (cand == switch_clean) begin
                    // Glitch settled back onto the code already presented.
                    cnt_nxt   = '0;
                    state_nxt = ST_STABLE;
                end else if (cnt == CNT_MAX) begin
                    clean_nxt  = cand;
                    strobe_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = ST_STABLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_STABLE;
            end
        endcase
    end

    // Candidate, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand         <= '0;
            cnt          <= '0;
            switch_clean <= '0;
            code_strobe  <= 1'b0;
        end else begin
            cand         <= cand_nxt;
            cnt          <= cnt_nxt;
            switch_clean <= clean_nxt;
            code_strobe  <= strobe_nxt;
        end
    end

    // Output decode: stable is a direct function of the state flop.
    always_comb begin
        stable = (state == ST_STABLE);
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - randomized and directed checks against a run-length debounce model
module tb_switch_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] switch_raw;
    logic [2:0] switch_clean;
    logic       code_strobe;
    logic       stable;

    int errors = 0;
    int checks = 0;

    // Reference model: s is raw delayed SS edges; a code is accepted once it has
    // been the sampled value on DC+1 consecutive edges and differs from clean.
    logic [2:0] m_hist[$];
    logic [2:0] m_prev_s;
    int         m_run;
    logic [2:0] m_clean;
    logic       m_strobe;
    logic       m_stable;
    int         strobes;

    switch_conditioner #(
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switch_raw   (switch_raw),
        .switch_clean (switch_clean),
        .code_strobe  (code_strobe),
        .stable       (stable)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < SS; i++) m_hist.push_back(3'b000);
        m_prev_s = 3'b000;
        m_run    = 1;
        m_clean  = 3'b000;
        m_strobe = 1'b0;
        m_stable = 1'b1;
    endtask

    task automatic model_edge();
        logic [2:0] s;
        logic       same;
        if (!rst_n) begin
            model_reset();
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(switch_raw);
            same     = (s == m_prev_s);
            m_run    = same ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
            m_strobe = 1'b0;
            if (s != m_clean && m_run == DC + 1) begin
                m_clean  = s;
                m_strobe = 1'b1;
            end
            m_stable = (s == m_clean) && (m_stable || same);
            m_prev_s = s;
        end
    endtask

    // One clock: model follows the rising edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("clean",  switch_clean, m_clean);
        check("strobe", code_strobe,  m_strobe);
        check("stable", stable,       m_stable);
        if (code_strobe) strobes++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_clean",  switch_clean, 3'b000);
        check("rst_strobe", code_strobe,  1'b0);
        check("rst_stable", stable,       1'b1);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int len;
        logic [2:0] v;
        rst_n      = 1'b0;
        switch_raw = 3'b000;
        strobes    = 0;
        model_reset();
        @(negedge clk);

        // Reset with raw=000: outputs idle for 10 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s1_clean",  switch_clean, 3'b000);
            check("s1_strobe", code_strobe,  1'b0);
            check("s1_stable", stable,       1'b1);
        end

        // 000 -> 101: accepted on edge 6, stable low on edges 2..5.
        switch_raw = 3'b101;
        strobes = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("s2_clean",  switch_clean, (e >= 6) ? 3'b101 : 3'b000);
            check("s2_strobe", code_strobe,  (e == 6) ? 1'b1 : 1'b0);
            check("s2_stable", stable,       (e >= 2 && e <= 5) ? 1'b0 : 1'b1);
        end
        check("s2_strobes", strobes, 1);

        // Short 101 pulse is rejected.
        do_reset();
        strobes = 0;
        switch_raw = 3'b101;
        tick();
        tick();
        switch_raw = 3'b000;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("s3_clean", switch_clean, 3'b000);
        end
        check("s3_strobes", strobes, 0);
        check("s3_stable",  stable,  1'b1);

        // Alternating 110/111 then 110 held: single strobe 6 edges after last change.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            switch_raw = (i % 2 == 1) ? 3'b111 : 3'b110;
            tick();
        end
        strobes = 0;
        switch_raw = 3'b110;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (e == 5) check("s4_clean_e5", switch_clean, 3'b000);
            if (e == 6) check("s4_clean_e6", switch_clean, 3'b110);
            if (e == 6) check("s4_strobe_e6", code_strobe, 1'b1);
        end
        check("s4_strobes", strobes, 1);

        // Reset mid-settle discards 011; after release it is accepted normally.
        do_reset();
        strobes = 0;
        switch_raw = 3'b011;
        tick();
        tick();
        tick();
        check("s5_settling", stable, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("s5_rst_clean",  switch_clean, 3'b000);
        check("s5_rst_strobe", code_strobe,  1'b0);
        check("s5_rst_stable", stable,       1'b1);
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (e == 5) check("s5_clean_e5", switch_clean, 3'b000);
            if (e == 6) check("s5_clean_e6", switch_clean, 3'b011);
        end
        check("s5_strobes", strobes, 1);

        // With clean=111 a one-cycle dip to 101 produces nothing.
        switch_raw = 3'b111;
        for (int i = 0; i < 8; i++) tick();
        check("s6_clean_pre", switch_clean, 3'b111);
        strobes = 0;
        switch_raw = 3'b101;
        tick();
        switch_raw = 3'b111;
        for (int i = 0; i < 10; i++) tick();
        check("s6_clean",   switch_clean, 3'b111);
        check("s6_strobes", strobes, 0);

        // Random bouncing levels with occasional resets, every cycle against the model.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end
            v   = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 7);
            switch_raw = v;
            for (int k = 0; k < len; k++) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
